gray_seq_monitor: RTL
=====================

// Module: gray_seq_monitor
// PURPOSE
//  Receive-side companion to the 3-bit Gray-code sequencer. Samples a Gray-coded
//  bus, decodes it to binary (1-cycle registered latency), and checks each new
//  sample is the legal next Gray step. Reports lock status, wrap events and a
//  saturating error count. Sits on the sequencer's output or a board-level bus.
// PARAMETERS
//  WIDTH       3  Gray/binary bus width (>=2)
//  LOCK_STEPS  2  consecutive legal +1 steps needed to enter LOCKED (>=1)
//  ERR_W       8  width of err_count
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  valid_in   in   1      gray_in is sampled this cycle
//  gray_in    in   WIDTH  Gray-coded value
//  clr_err    in   1      synchronous clear of err_count
//  bin_out    out  WIDTH  decoded binary of the last accepted sample
//  bin_valid  out  1      1-cycle pulse: bin_out updated
//  locked     out  1      1 while FSM is in LOCKED
//  step_err   out  1      1-cycle pulse: illegal step detected (LOCKED only)
//  wrap_pulse out  1      1-cycle pulse: legal step max->0 while LOCKED
//  err_count  out  ERR_W  saturating count of step_err events
// BEHAVIOUR
//  Reset (async assert, sync release): bin_out=0, bin_valid=0, locked=0,
//   step_err=0, wrap_pulse=0, err_count=0, FSM=SEARCH, have_prev=0, good_cnt=0.
//  Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Combinational decode, registered out.
//  On valid_in=1 at edge N: bin_out, bin_valid, step_err, wrap_pulse all update
//   at edge N (visible cycle N+1). valid_in=0 -> pulses return to 0, bin_out holds.
//  prev = previous accepted binary value. Step classes, mod 2^WIDTH arithmetic:
//   NEXT: new==prev+1 (incl. max->0); HOLD: new==prev; BAD: anything else.
//  FSM SEARCH:
//   - have_prev=0: capture sample, have_prev<=1, good_cnt<=0, no error.
//   - NEXT: good_cnt+1; reaching LOCK_STEPS -> LOCKED, good_cnt<=0.
//   - HOLD: good_cnt unchanged. BAD: good_cnt<=0. Never asserts step_err.
//   - wrap_pulse never asserted in SEARCH.
//  FSM LOCKED:
//   - NEXT: stay; wrap_pulse=1 if prev==2^WIDTH-1 and new==0.
//   - HOLD: stay, no error (repeated sample is legal).
//   - BAD: step_err=1, err_count+1 (saturate at all-ones), -> SEARCH, good_cnt<=0;
//     the bad sample becomes prev (re-acquire starts from it).
//  locked follows FSM state registered: goes 0 in the same edge as step_err.
//  clr_err=1: err_count<=0; if simultaneous with BAD, clear wins (count=0),
//   step_err pulse still asserted.
//  bin_out always reflects the latest sample, legal or not.
//  Reset mid-operation: all state returns to reset values immediately; first
//   sample after release is treated as have_prev=0.
// TESTING
//  1 Reset, feed 000,001,011,010,110,111,101,100,000 (valid each cycle) ->
//    bin_out 0..7,0; locked=1 after the 3rd sample's edge; wrap_pulse on final 000;
//    err_count=0.
//  2 Locked at bin 3 (gray 010), feed 010 twice then 110 -> no step_err, stays
//    locked, bin_out 3,3,4.
//  3 Locked at gray 011, feed 110 (skip) -> step_err=1 one cycle, locked=0,
//    err_count=1, bin_out=4; then 111,101 -> locked=1 again, err_count=1.
//  4 Force 300 illegal steps with re-lock between each (ERR_W=8) -> err_count
//    saturates at 255; assert clr_err with a BAD step -> err_count=0, step_err=1.
//  5 valid_in toggled 0/1 with legal sequence -> bin_valid only on sampled
//    cycles, gaps never cause errors, locking identical to test 1.
//  6 Assert rst_n=0 mid-sequence while LOCKED -> all outputs 0 asynchronously;
//    after release feed 101 then 100 -> no step_err, good_cnt=1, locked=0.

Source files
------------

// File: rtl/gray_seq_monitor.sv
// Gray-code bus monitor: decodes samples to binary, checks each is the
// next legal step, and tracks lock, wrap events and a saturating error count.
module gray_seq_monitor #(
  parameter int WIDTH      = 3,
  parameter int LOCK_STEPS = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             step_err,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = (LOCK_STEPS < 2) ? 1 : $clog2(LOCK_STEPS + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [GW-1:0] LAST = GW'(LOCK_STEPS - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state_q, state_d;
  logic             have_q, have_d;
  logic [GW-1:0]    good_q, good_d;
  logic [WIDTH-1:0] bin_d, dec, bin_inc;
  logic             bv_d, se_d, wp_d;
  logic [ERR_W-1:0] err_d;
  logic             is_next, is_hold;

  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      dec[i] = ^(gray_in >> i);
  end

  // bin_out doubles as the previous accepted sample
  assign bin_inc = bin_out + ONE;
  assign is_next = (dec == bin_inc);
  assign is_hold = (dec == bin_out);

  always_comb begin
    state_d = state_q;
    have_d  = have_q;
    good_d  = good_q;
    bin_d   = bin_out;
    bv_d    = 1'b0;
    se_d    = 1'b0;
    wp_d    = 1'b0;
    err_d   = err_count;
    if (valid_in) begin
      bin_d  = dec;
      bv_d   = 1'b1;
      have_d = 1'b1;
      if (!have_q) begin
        good_d = '0;
      end else begin
        unique case (state_q)
          SEARCH: begin
            if (is_next) begin
              if (good_q == LAST) begin
                state_d = LOCKED;
                good_d  = '0;
              end else begin
                good_d = good_q + GW'(1);
              end
            end else if (!is_hold) begin
              good_d = '0;
            end
          end
          LOCKED: begin
            if (is_next) begin
              wp_d = (bin_out == '1) && (dec == '0);
            end else if (!is_hold) begin
              se_d    = 1'b1;
              state_d = SEARCH;
              good_d  = '0;
              if (err_count != '1)
                err_d = err_count + ERR_W'(1);
            end
          end
          default: state_d = SEARCH;
        endcase
      end
    end
    if (clr_err)
      err_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      have_q     <= 1'b0;
      good_q     <= '0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      step_err   <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      have_q     <= have_d;
      good_q     <= good_d;
      bin_out    <= bin_d;
      bin_valid  <= bv_d;
      step_err   <= se_d;
      wrap_pulse <= wp_d;
      err_count  <= err_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule
